// File: rtl/otter_ctrl_pkg.sv
// otter_ctrl_pkg: shared state type and default timing constants for the OTTER run controller
package otter_ctrl_pkg;
    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        HALTED   = 3'd1,
        STEP     = 3'd2,
        RUNNING  = 3'd3
    } run_state_t;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_DB_CYCLES  = 1000000;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer, stability debounce and rising-edge pulse for one board button
//  clk, s_reset : clock, synchronous active-high reset
//  btn          : raw asynchronous bouncy button
//  pulse        : one-clk pulse when a press is accepted (registered)
module button_debounce
    import otter_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic s_reset,
    input  logic btn,
    output logic pulse
);
    localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          done;
    assign done = cnt == CW'(DB_CYCLES - 1);
    // level follows the synchronized input only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (s_reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (done) begin
                level <= sync[1];
                cnt   <= '0;
                pulse <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/otter_run_ctrl.sv
// otter_run_ctrl: OTTER MCU run controller driving mcu_reset and a rate-selectable clock enable
//  clk, s_reset : clock, synchronous active-high reset
//  btn_run      : run/halt toggle button (raw)
//  btn_step     : single-step button (raw)
//  btn_init     : re-init button, re-runs the MCU reset hold (raw)
//  div_sel      : CE period exponent, period = 2**div_sel clk cycles
//  mcu_reset    : reset to the MCU (registered)
//  mcu_ce       : one-clk clock enable to the MCU (registered)
//  running      : high while RUNNING
//  state_o      : state encoding RST_HOLD=0 HALTED=1 STEP=2 RUNNING=3
module otter_run_ctrl
    import otter_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter bit START_RUN  = 1'b1,
    parameter int DIV_W      = 5
) (
    input  logic             clk,
    input  logic             s_reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_init,
    input  logic [DIV_W-1:0] div_sel,
    output logic             mcu_reset,
    output logic             mcu_ce,
    output logic             running,
    output logic [2:0]       state_o
);
    localparam int CNT_W  = 2 ** DIV_W;
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    run_state_t       state, nxt;
    logic [HOLD_W-1:0] hold;
    logic [CNT_W-1:0]  div, div_max;
    logic [DIV_W-1:0]  sel_q;
    logic run_p, step_p, init_p, hold_last, wrap, sel_chg;
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run  (.clk(clk), .s_reset(s_reset), .btn(btn_run),  .pulse(run_p));
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (.clk(clk), .s_reset(s_reset), .btn(btn_step), .pulse(step_p));
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_init (.clk(clk), .s_reset(s_reset), .btn(btn_init), .pulse(init_p));
    assign div_max   = (CNT_W'(1) << div_sel) - CNT_W'(1);
    assign wrap      = div == div_max;
    assign sel_chg   = div_sel != sel_q;
    assign hold_last = hold == HOLD_W'(RST_CYCLES - 1);
    assign state_o   = state;
    always_comb begin
        nxt = state;
        if (init_p) nxt = RST_HOLD;
        else case (state)
            RST_HOLD: if (hold_last) nxt = START_RUN ? RUNNING : HALTED;
            HALTED:   nxt = run_p ? RUNNING : step_p ? STEP : HALTED;
            STEP:     nxt = HALTED;
            RUNNING:  nxt = run_p ? HALTED : RUNNING;
            default:  nxt = RST_HOLD;
        endcase
    end
    // Outputs are computed from the next state so they change together with state_o.
    // On entry to RUNNING or a rate change the period restarts: only div_sel=0 fires immediately.
    always_ff @(posedge clk) begin
        sel_q <= div_sel;
        if (s_reset) begin
            state     <= RST_HOLD;
            hold      <= '0;
            div       <= '0;
            mcu_reset <= 1'b1;
            mcu_ce    <= 1'b1;
            running   <= 1'b0;
        end else begin
            state     <= nxt;
            hold      <= (state == RST_HOLD && nxt == RST_HOLD && !init_p) ? hold + HOLD_W'(1) : '0;
            div       <= (state == RUNNING && nxt == RUNNING && !sel_chg && !wrap) ? div + CNT_W'(1) : '0;
            mcu_reset <= nxt == RST_HOLD;
            mcu_ce    <= nxt == RST_HOLD || nxt == STEP ||
                         (nxt == RUNNING && ((state != RUNNING || sel_chg) ? div_sel == '0 : wrap));
            running   <= nxt == RUNNING;
        end
    end
endmodule

// File: tb/tb_otter_run_ctrl.sv
// tb_otter_run_ctrl: randomized scoreboard bench for otter_run_ctrl against a behavioural timeline model
module tb_otter_run_ctrl;
    localparam int RST       = 4;
    localparam int DB        = 4;
    localparam bit START_RUN = 1'b1;
    localparam int LAT       = 2 + DB + 1;
    logic       clk = 1'b0, s_reset = 1'b1, btn_run = 1'b0, btn_step = 1'b0, btn_init = 1'b0;
    logic [4:0] div_sel = '0;
    logic       mcu_reset, mcu_ce, running;
    logic [2:0] state_o;
    typedef struct {int cyc; int st; bit ce;} ev_t;
    ev_t        q[$];
    ev_t        ev;
    bit         run_at[int], step_at[int], init_at[int];
    int         cyc = 0, checks = 0, failures = 0;
    int         m_st = 0, m_prev = -1, m_hold = 0, m_anchor = 0;
    logic [4:0] m_psel = '0;
    logic [4:0] prev;

    otter_run_ctrl #(.RST_CYCLES(RST), .DB_CYCLES(DB), .START_RUN(START_RUN), .DIV_W(5)) dut (
        .clk(clk), .s_reset(s_reset), .btn_run(btn_run), .btn_step(btn_step), .btn_init(btn_init),
        .div_sel(div_sel), .mcu_reset(mcu_reset), .mcu_ce(mcu_ce), .running(running), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output at sample t (just after posedge t), from the state rules: reset hold lasts
    // RST samples from its start; in RUNNING the CE falls every 2**div_sel cycles after the anchor
    // (entry or rate change), with div_sel=0 also firing on the anchor itself.
    task automatic model(int t);
        int p;
        bit ce, chg;
        chg    = div_sel != m_psel;
        m_psel = div_sel;
        if (s_reset || init_at.exists(t)) begin
            m_st   = 0;
            m_hold = t;
        end else if (m_st == 0) begin
            if (t == m_hold + RST) begin
                m_st     = START_RUN ? 3 : 1;
                m_anchor = t;
            end
        end else if (m_st == 1) begin
            if (run_at.exists(t)) begin
                m_st     = 3;
                m_anchor = t;
            end else if (step_at.exists(t)) m_st = 2;
        end else if (m_st == 2) m_st = 1;
        else if (run_at.exists(t)) m_st = 1;
        else if (chg) m_anchor = t;
        p  = 1 << div_sel;
        ce = m_st == 0 || m_st == 2 || (m_st == 3 && (t - m_anchor) % p == 0 && (t > m_anchor || p == 1));
        if (ce || m_st != m_prev) q.push_back('{t, m_st, ce});
        m_prev = m_st;
    endtask

    task automatic tick();
        model(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(int b, bit v);
        if (b == 0) btn_run = v;
        else if (b == 1) btn_step = v;
        else btn_init = v;
    endtask

    task automatic press(bit r, bit s, bit i);
        if (r) run_at[cyc + LAT] = 1'b1;
        if (s) step_at[cyc + LAT] = 1'b1;
        if (i) init_at[cyc + LAT] = 1'b1;
        btn_run  = r;
        btn_step = s;
        btn_init = i;
        repeat (6) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_init = 1'b0;
        repeat (8) tick();
    endtask

    task automatic bounce(int b);
        for (int j = 0; j < 4; j++) begin
            set_btn(b, j % 2 == 0);
            tick();
        end
        set_btn(b, 1'b0);
        repeat (8) tick();
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event cyc=%0d: DUT showed no event, required state=%0d ce=%0d", q[0].cyc, q[0].st, q[0].ce);
                void'(q.pop_front());
            end
            if (mcu_ce || {state_o, mcu_reset, running} !== prev) begin
                checks++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d: got state=%0d reset=%0d ce=%0d running=%0d, required no event",
                             cyc, state_o, mcu_reset, mcu_ce, running);
                end else begin
                    ev = q.pop_front();
                    if (state_o !== 3'(ev.st) || mcu_reset !== (ev.st == 0) || mcu_ce !== ev.ce || running !== (ev.st == 3)) begin
                        failures++;
                        $display("FAIL event_value cyc=%0d: got state=%0d reset=%0d ce=%0d running=%0d, required state=%0d reset=%0d ce=%0d running=%0d",
                                 cyc, state_o, mcu_reset, mcu_ce, running, ev.st, ev.st == 0, ev.ce, ev.st == 3);
                    end
                end
            end
        end
        prev = {state_o, mcu_reset, running};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        s_reset = 1'b0;
        repeat (12) tick();
        div_sel = 5'd3;
        repeat ($urandom_range(20, 30)) tick();
        div_sel = 5'd1;
        repeat (10) tick();
        press(1'b1, 1'b0, 1'b0);
        bounce(0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        div_sel = 5'd2;
        repeat ($urandom_range(5, 12)) tick();
        press(1'b0, 1'b0, 1'b1);
        repeat (12) tick();
        press(1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        press(1'b1, 1'b0, 1'b0);
        step_at[cyc + LAT] = 1'b1;
        btn_step = 1'b1;
        repeat (6) tick();
        btn_step = 1'b0;
        tick();
        s_reset = 1'b1;
        repeat (3) tick();
        s_reset = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(1, 20)) tick();
                1: press(1'b1, 1'b0, 1'b0);
                2: press(1'b0, 1'b1, 1'b0);
                3: press(1'b0, 1'b0, 1'b1);
                4: begin
                    div_sel = 5'($urandom_range(0, 3));
                    repeat ($urandom_range(1, 12)) tick();
                end
                default: bounce(int'($urandom_range(0, 2)));
            endcase
        end
        repeat (10) tick();
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL missed_event cyc=%0d: DUT showed no event, required state=%0d ce=%0d", q[0].cyc, q[0].st, q[0].ce);
            void'(q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
